// File: rtl/fastbconv_sched.sv
// Round-robin arbiter sharing one fastBConv unit between NUM_REQ requesters.
// Latency: accept at t, start pulse t+1, response from t+2+IN_BASIS_LEN (or after TIMEOUT wait cycles).
// Backpressure: a response is held until consumed; no new job launches until then.
module fastbconv_sched #(
    parameter int NUM_REQ      = 4,
    parameter int IN_BASIS_LEN = 4,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic                       rsp_err,
    output logic [$clog2(NUM_REQ)-1:0] conv_sel,
    output logic                       conv_in_valid,
    input  logic                       conv_out_valid,
    input  logic                       conv_busy,
    output logic                       sched_busy,
    output logic                       timeout_err,
    output logic [CNT_W-1:0]           jobs_done
);

    localparam int SEL_W  = $clog2(NUM_REQ);
    localparam int WCNT_W = $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    if (NUM_REQ < 2 || TIMEOUT <= IN_BASIS_LEN + 1) begin : g_bad_cfg
        $error("fastbconv_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    winner;
    logic                win_vld;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                accept;
    logic                rsp_hs;
    logic                timed_out;

    // (a + k) mod NUM_REQ for a, k < NUM_REQ; one extra bit covers the carry.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int k);
        logic [SEL_W:0] s;
        s = {1'b0, a} + (SEL_W+1)'(k);
        if (s >= (SEL_W+1)'(NUM_REQ)) begin
            s = s - (SEL_W+1)'(NUM_REQ);
        end
        return s[SEL_W-1:0];
    endfunction

    // Scan downward so the requester closest above rr_ptr is the last to overwrite.
    always_comb begin
        winner  = rr_ptr;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) begin
                winner  = wrap_add(rr_ptr, k);
                win_vld = 1'b1;
            end
        end
    end

    assign accept        = reset && (state == IDLE) && win_vld && !conv_busy;
    assign req_ready     = accept ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_valid     = (state == RESP) ? (NUM_REQ'(1) << conv_sel) : '0;
    assign rsp_hs        = (state == RESP) && rsp_ready[conv_sel];
    assign conv_in_valid = (state == LAUNCH);
    assign sched_busy    = (state != IDLE);
    assign timed_out     = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (conv_out_valid || timed_out) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            conv_sel    <= '0;
            wait_cnt    <= '0;
            rsp_err     <= 1'b0;
            timeout_err <= 1'b0;
            jobs_done   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                conv_sel <= winner;
            end
            case (state)
                LAUNCH: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + WCNT_W'(1);
                    // A completion in the same cycle as the limit still counts as success.
                    if (conv_out_valid) begin
                        rsp_err <= 1'b0;
                    end else if (timed_out) begin
                        rsp_err     <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rr_ptr <= wrap_add(conv_sel, 1);
                        if (!rsp_err) begin
                            jobs_done <= jobs_done + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fastbconv_sched.sv
// Bench for fastbconv_sched: job-level reference model plus a behavioural conversion unit.
module tb_fastbconv_sched;

    localparam int NR  = 4;
    localparam int IBL = 4;
    localparam int TO  = 16;
    localparam int CW  = 16;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic              rsp_err;
    logic [1:0]        conv_sel;
    logic              conv_in_valid;
    logic              conv_out_valid;
    logic              conv_busy;
    logic              sched_busy;
    logic              timeout_err;
    logic [CW-1:0]     jobs_done;

    fastbconv_sched #(
        .NUM_REQ(NR), .IN_BASIS_LEN(IBL), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .conv_sel(conv_sel), .conv_in_valid(conv_in_valid),
        .conv_out_valid(conv_out_valid), .conv_busy(conv_busy),
        .sched_busy(sched_busy), .timeout_err(timeout_err), .jobs_done(jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // stimulus knobs
    logic [NR-1:0] drv_req   = '0;
    bit            req_rand  = 0;
    int            rdy_pct   = 100;
    bit            busy_rand = 0;
    bit            force_busy = 0;
    int            u_mode    = 0;   // 0 normal, 1 never completes, 2 out_valid stuck high
    int            u_start   = -1;
    bit            rec_grants = 0;
    int            obs_grants[$];

    // job-level reference model
    bit            m_busy = 0;
    int            m_win  = 0;
    int            m_acc  = 0;
    int            m_resp = -1;
    bit            m_err  = 0;
    bit            m_terr = 0;
    int            m_rr   = 0;
    int            m_jobs = 0;
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_rsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        req_valid = req_rand ? NR'($urandom) : drv_req;
        for (int i = 0; i < NR; i++) rsp_ready[i] = ($urandom_range(99) < rdy_pct);
        conv_out_valid = (u_mode == 2) || (u_mode == 0 && u_start >= 0 && cyc >= u_start + IBL);
        conv_busy = force_busy || (busy_rand && $urandom_range(3) == 0) ||
                    (u_mode == 0 && u_start >= 0 && cyc > u_start && cyc < u_start + IBL);
        #1;
        exp_rdy = '0;
        if (!m_busy && !conv_busy && req_valid != '0) exp_rdy[rr_pick(req_valid, m_rr)] = 1'b1;
        exp_rsp = '0;
        if (m_busy && m_resp >= 0 && cyc >= m_resp) exp_rsp[m_win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        check("conv_in_valid", 32'(conv_in_valid), 32'(m_busy && cyc == m_acc + 1));
        check("sched_busy", 32'(sched_busy), 32'(m_busy));
        check("jobs_done", 32'(jobs_done), 32'(m_jobs));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (exp_rsp != '0) check("rsp_err", 32'(rsp_err), 32'(m_err));
        if (m_busy && cyc > m_acc) check("conv_sel", 32'(conv_sel), 32'(m_win));
        if (rec_grants) begin
            for (int i = 0; i < NR; i++) if (req_ready[i]) obs_grants.push_back(i);
        end
        if (conv_in_valid) u_start = cyc;
        // advance the model with what was applied this cycle
        if (!m_busy) begin
            if (exp_rdy != '0) begin
                m_busy = 1; m_win = rr_pick(req_valid, m_rr); m_acc = cyc; m_resp = -1;
            end
        end else if (m_resp < 0) begin
            if (cyc >= m_acc + 2) begin
                if (conv_out_valid) begin
                    m_resp = cyc + 1; m_err = 0;
                end else if (cyc == m_acc + 1 + TO) begin
                    m_resp = cyc + 1; m_err = 1; m_terr = 1;
                end
            end
        end else if (cyc >= m_resp && rsp_ready[m_win]) begin
            if (!m_err) m_jobs = (m_jobs + 1) & 32'hFFFF;
            m_rr = (m_win + 1) % NR;
            m_busy = 0;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; rsp_ready = '0; conv_out_valid = 1'b0; conv_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_sched_busy", 32'(sched_busy), 32'd0);
        check("rst_conv_in_valid", 32'(conv_in_valid), 32'd0);
        check("rst_jobs_done", 32'(jobs_done), 32'd0);
        check("rst_conv_sel", 32'(conv_sel), 32'd0);
        reset = 1'b1;

        // fairness: everyone requesting, responses consumed at once
        drv_req = 4'b1111; rec_grants = 1;
        for (int g = 0; g < 200 && obs_grants.size() < 6; g++) step();
        drv_req = '0; rec_grants = 0;
        check("grant_count", 32'(obs_grants.size()), 32'd6);
        for (int i = 0; i < obs_grants.size(); i++) check("grant_order", 32'(obs_grants[i]), 32'(i % NR));
        run(12);

        // single job
        drv_req = 4'b0001; step(); drv_req = '0; run(10);

        // response backpressure with another request pending
        drv_req = 4'b0001; step(); drv_req = 4'b0010; rdy_pct = 0;
        run(6 + 10);
        rdy_pct = 100; run(3); drv_req = '0; run(10);

        // out_valid stuck high through launch
        u_mode = 2; drv_req = 4'b0100; step(); drv_req = '0; run(6); u_mode = 0; run(2);

        // unit never completes
        u_mode = 1; drv_req = 4'b1000; step(); drv_req = '0; run(TO + 6);
        check("terr_sticky", 32'(timeout_err), 32'd1);
        u_mode = 0; run(2);

        // unit busy blocks acceptance
        force_busy = 1; drv_req = 4'b0001; run(5);
        force_busy = 0; step(); drv_req = '0; run(10);

        // randomized traffic
        req_rand = 1; rdy_pct = 60; busy_rand = 1;
        for (int b = 0; b < 15; b++) begin
            u_mode = ($urandom_range(9) == 0) ? 1 : (($urandom_range(3) == 0) ? 2 : 0);
            run(100);
        end
        req_rand = 0; drv_req = '0; rdy_pct = 100; busy_rand = 0; u_mode = 0;
        run(30);

        // asynchronous reset mid-WAIT
        drv_req = 4'b0001; step(); drv_req = '0; run(3);
        @(negedge clk);
        req_valid = 4'b1111; rsp_ready = 4'b1111;
        #2 reset = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_err", 32'(rsp_err), 32'd0);
        check("arst_conv_in_valid", 32'(conv_in_valid), 32'd0);
        check("arst_sched_busy", 32'(sched_busy), 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        check("arst_jobs_done", 32'(jobs_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; req_valid = '0;
        m_busy = 0; m_rr = 0; m_jobs = 0; m_terr = 0; m_err = 0; u_start = -1;
        drv_req = 4'b1111; step(); drv_req = '0; run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fastbconv_sched.md
Name: fastbconv_sched

Overview:
- Round-robin scheduler that shares one fastBConv polynomial unit between NUM_REQ requesters, for example ModUp/ModDown callers for different ciphertext components.
- Accepts jobs through a valid/ready request handshake.
- Drives the conversion unit's select mux and its single-cycle start pulse, then waits for completion.
- Returns a per-requester response, holding off the next launch until the current result is consumed, because the unit's output register is overwritten by the next start.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- IN_BASIS_LEN, 4, input basis length of the shared unit; sets nominal latency.
- TIMEOUT, 16, WAIT-state cycle limit before abort (must be > IN_BASIS_LEN+1).
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept; handshake completes when req_valid[i]&req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot result available in the shared unit's output register.
- rsp_ready  in  NUM_REQ  requester has consumed the result.
- rsp_err  out  1  qualifies rsp_valid; 1 = job aborted by timeout, data invalid.
- conv_sel  out  $clog2(NUM_REQ)  selects the requester's input polynomial into the unit and routes its output.
- conv_in_valid  out  1  start pulse to the unit's in_valid.
- conv_out_valid  in  1  unit out_valid (level; stays high until the next start).
- conv_busy  in  1  unit doing_fastBconv.
- sched_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky error flag; cleared only by reset.
- jobs_done  out  CNT_W  count of successful (rsp_err=0) response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, conv_sel=0, wait counter=0, jobs_done=0, timeout_err=0. All outputs are 0: req_ready, rsp_valid, rsp_err, conv_in_valid, sched_busy.
- Reset mid-job abandons the job silently with no response. The unit has its own reset.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Winner is the first i with req_valid[i]=1, searching from rr_ptr upward, wrapping at NUM_REQ.
  - req_ready[winner]=1 combinationally, but only if conv_busy=0. If conv_busy=1, no request is accepted.
  - On handshake: conv_sel<=winner, next state LAUNCH.
  - Non-winners see req_ready=0.
- LAUNCH (exactly 1 cycle):
  - conv_in_valid=1 and wait counter<=0; next state WAIT.
  - The accepted requester holds its input polynomial stable from the handshake cycle through the LAUNCH cycle.
  - conv_out_valid is ignored in this cycle, since it may be stale from the prior job.
- WAIT:
  - Counter increments each cycle.
  - If conv_out_valid=1: next state RESP, rsp_err<=0.
  - Else if counter reaches TIMEOUT-1: timeout_err<=1, rsp_err<=1, next state RESP.
  - If out_valid and the timeout coincide, out_valid wins (rsp_err=0).
- RESP:
  - rsp_valid[conv_sel]=1, held until rsp_ready[conv_sel]=1.
  - On handshake: rr_ptr<=(conv_sel+1) mod NUM_REQ; jobs_done += 1 if rsp_err=0; next state IDLE.
  - rsp_ready from other requesters is ignored.
- No new request is accepted in the same cycle as a RESP handshake; the earliest next accept is the following IDLE cycle.
- Nominal latency:
  - Request accepted in cycle t.
  - conv_in_valid in t+1.
  - conv_out_valid first high at t+1+IN_BASIS_LEN.
  - rsp_valid in t+2+IN_BASIS_LEN.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other jobs.
- A request withdrawn before its handshake is simply not served.
- conv_sel is held stable from LAUNCH through the end of RESP.

Test Plan:
- Single job: req_valid=0001 in IDLE, IN_BASIS_LEN=4, model unit -> req_ready=0001 same cycle; conv_in_valid 1 cycle later; rsp_valid=0001 6 cycles after accept; rsp_ready -> jobs_done=1, rr_ptr=1.
- Fairness: req_valid=1111 held continuously, rsp_ready tied high -> grant order 0,1,2,3,0,1; exactly one conv_in_valid per job; never two outstanding.
- Backpressure: rsp_ready low for 10 cycles in RESP with req_valid=0010 pending -> rsp_valid stays high; no conv_in_valid and req_ready=0 until rsp handshake; requester 1 is accepted the cycle after returning to IDLE.
- Stale out_valid: conv_out_valid held high across a launch -> LAUNCH ignores it; RESP is entered no earlier than the first WAIT cycle.
- Timeout: model never asserts conv_out_valid, TIMEOUT=16 -> after 16 WAIT cycles rsp_valid=1 with rsp_err=1 and timeout_err=1 (sticky); jobs_done unchanged.
- Reset/guard:
  - reset=0 asynchronously during WAIT -> all outputs 0 immediately; state IDLE, rr_ptr=0 after release.
  - conv_busy=1 in IDLE with req_valid=0001 -> no req_ready until conv_busy=0.
